psram_req_queue: RTL and testbench

Request queue between the picoBlaze application logic and the PSRAM controller (`psram_ctrlr`). It accepts single-word read and write requests into a FIFO and issues them one at a time using the controller's strobe / `app_op_begun` / `op_finished` handshake. Read data comes back as a one-cycle response pulse. The application can therefore post writes back-to-back without waiting for each memory cycle to finish. Burst operations are never issued.

---
 rtl/psram_req_queue.sv | 184 ++++++++++++++++++
 tb/tb_psram_req_queue.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_req_queue.sv
// psram_req_queue
// Posted request queue between the application logic and psram_ctrlr.
// Single-word read/write requests are stored in a FIFO and issued one at a
// time with the controller's strobe / app_op_begun / op_finished handshake.
// Read data returns as a one-cycle rsp_valid pulse. Bursts are never issued.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   req_*              request input (valid, wr, addr, data, ub, lb)
//   req_ready          registered "queue not full"
//   rsp_valid/rsp_data one-cycle read-data response
//   q_level            FIFO occupancy, busy = queue non-empty or op in flight
//   app_*              strobes, address, data and byte enables to controller
//   app_data_in/ok     read data and data-ready from controller
//   app_op_begun       controller accepted the strobed operation
//   op_finished        controller completed the operation
//   ctrlr_good         controller initialised; gates new issues only
module psram_req_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_wr,
  input  logic [22:0]         req_addr,
  input  logic [15:0]         req_data,
  input  logic                req_ub,
  input  logic                req_lb,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [15:0]         rsp_data,
  output logic [DEPTH_LOG2:0] q_level,
  output logic                busy,
  output logic                app_wr,
  output logic                app_rd,
  output logic [22:0]         app_addr,
  output logic [15:0]         app_data_out,
  output logic                app_ub,
  output logic                app_lb,
  output logic                app_burst_op,
  input  logic [15:0]         app_data_in,
  input  logic                app_data_ok,
  input  logic                app_op_begun,
  input  logic                op_finished,
  input  logic                ctrlr_good
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_FIN = 2'd2
  } state_t;

  // Entry layout: {wr, addr[22:0], data[15:0], ub, lb}
  logic [41:0]           mem_r [DEPTH];
  logic [41:0]           head_s;
  logic [41:0]           entry_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  state_t                state_r;
  state_t                state_nxt_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  req_ready_r;
  logic                  busy_r;
  logic                  app_wr_r;
  logic                  app_rd_r;
  logic [22:0]           app_addr_r;
  logic [15:0]           app_data_out_r;
  logic                  app_ub_r;
  logic                  app_lb_r;
  logic                  cur_rd_r;
  logic                  dok_q_r;
  logic                  dok_seen_r;
  logic                  rsp_valid_r;
  logic [15:0]           rsp_data_r;

  assign head_s       = mem_r[rd_ptr_r];
  assign entry_s      = {req_wr, req_addr, req_data, req_ub, req_lb};
  assign req_ready    = req_ready_r;
  assign busy         = busy_r;
  assign q_level      = count_r;
  assign app_wr       = app_wr_r;
  assign app_rd       = app_rd_r;
  assign app_addr     = app_addr_r;
  assign app_data_out = app_data_out_r;
  assign app_ub       = app_ub_r;
  assign app_lb       = app_lb_r;
  assign app_burst_op = 1'b0;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;

  // Push/pop decisions, next occupancy and next FSM state
  always_comb begin
    push_s      = req_valid & req_ready_r;
    pop_s       = (state_r == ST_IDLE) && (count_r != LVL_ZERO) && ctrlr_good;
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + LVL_ONE;
      2'b01:   count_nxt_s = count_r - LVL_ONE;
      default: count_nxt_s = count_r;
    endcase
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_ISSUE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (app_op_begun) state_nxt_s = ST_WAIT_FIN;
        else              state_nxt_s = ST_ISSUE;
      end
      ST_WAIT_FIN: begin
        if (op_finished) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_WAIT_FIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= entry_s;
  end

  // Pointers, occupancy, issue FSM, controller outputs and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r       <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      count_r        <= LVL_ZERO;
      state_r        <= ST_IDLE;
      req_ready_r    <= 1'b1;
      busy_r         <= 1'b0;
      app_wr_r       <= 1'b0;
      app_rd_r       <= 1'b0;
      app_addr_r     <= 23'd0;
      app_data_out_r <= 16'd0;
      app_ub_r       <= 1'b0;
      app_lb_r       <= 1'b0;
      cur_rd_r       <= 1'b0;
      dok_q_r        <= 1'b0;
      dok_seen_r     <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_data_r     <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      // Both flags reflect the post-edge occupancy/state so they stay exact
      req_ready_r <= (count_nxt_s != LVL_FULL);
      busy_r      <= (count_nxt_s != LVL_ZERO) || (state_nxt_s != ST_IDLE);
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      // Only the first data_ok of a read is taken, even if it is held high
      dok_q_r <= app_data_ok & cur_rd_r & (state_r != ST_IDLE) & ~dok_seen_r & ~dok_q_r;
      if (dok_q_r) dok_seen_r <= 1'b1;
      if (pop_s) begin
        rd_ptr_r       <= rd_ptr_r + PTR_ONE;
        app_wr_r       <= head_s[41];
        app_rd_r       <= ~head_s[41];
        app_addr_r     <= head_s[40:18];
        app_data_out_r <= head_s[17:2];
        app_ub_r       <= head_s[1];
        app_lb_r       <= head_s[0];
        cur_rd_r       <= ~head_s[41];
        dok_seen_r     <= 1'b0;
      end else if ((state_r == ST_ISSUE) && app_op_begun) begin
        app_wr_r <= 1'b0;
        app_rd_r <= 1'b0;
      end
      rsp_valid_r <= dok_q_r;
      if (dok_q_r) rsp_data_r <= app_data_in;
    end
  end

endmodule

// File: tb/tb_psram_req_queue.sv
// Testbench for psram_req_queue: directed handshake/timing checks plus a
// randomized run against a transaction-level reference (FIFO of requests and
// a word-addressed memory image), with a scoreboard monitor that compares
// every issued operation and every read response.
module tb_psram_req_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        wr;
    logic [22:0] addr;
    logic [15:0] data;
    logic        ub;
    logic        lb;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_ub = 1'b0, req_lb = 1'b0;
  logic [22:0] req_addr = 23'd0;
  logic [15:0] req_data = 16'd0;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_data;
  logic [3:0]  q_level;
  logic        app_wr, app_rd, app_ub, app_lb, app_burst_op;
  logic [22:0] app_addr;
  logic [15:0] app_data_out;
  logic [15:0] app_data_in = 16'd0;
  logic        app_data_ok = 1'b0, app_op_begun = 1'b0, op_finished = 1'b0;
  logic        ctrlr_good = 1'b0;
  logic        ctl_auto = 1'b0;

  int errors = 0;
  int checks = 0;
  int m_level = 0;
  req_t        exp_q[$];
  logic [15:0] exp_rsp[$];
  logic [15:0] ref_mem [bit [22:0]];
  logic [15:0] ctl_mem [bit [22:0]];

  psram_req_queue #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_ub(req_ub), .req_lb(req_lb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .q_level(q_level), .busy(busy),
    .app_wr(app_wr), .app_rd(app_rd), .app_addr(app_addr), .app_data_out(app_data_out),
    .app_ub(app_ub), .app_lb(app_lb), .app_burst_op(app_burst_op),
    .app_data_in(app_data_in), .app_data_ok(app_data_ok), .app_op_begun(app_op_begun),
    .op_finished(op_finished), .ctrlr_good(ctrlr_good)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mem_read(input bit ctl, input bit [22:0] a);
    if (ctl) return ctl_mem.exists(a) ? ctl_mem[a] : 16'h0000;
    else     return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic void mem_write(input bit ctl, input bit [22:0] a, input logic [15:0] d,
                                    input logic ub, input logic lb);
    logic [15:0] old;
    logic [15:0] nw;
    old = mem_read(ctl, a);
    nw  = {ub ? d[15:8] : old[15:8], lb ? d[7:0] : old[7:0]};
    if (ctl) ctl_mem[a] = nw;
    else     ref_mem[a] = nw;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic wr, input logic [22:0] a, input logic [15:0] d,
                         input logic ub, input logic lb);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d; req_ub = ub; req_lb = lb;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_rsp.size() != 0 || busy) && n < 3000) begin
      cyc(1);
      n++;
    end
    cyc(4);
    chk({tag, "_drain_timeout"}, 64'(n >= 3000), 64'd0);
    chk({tag, "_drain_level"}, 64'(q_level), 64'd0);
  endtask

  // Reference model: accepted requests in arrival order; reads take their
  // expected data from the memory image as it stands after earlier requests
  initial begin
    forever begin
      @(posedge clk);
      if (reset && req_valid && (m_level != DEPTH)) begin
        exp_q.push_back('{wr: req_wr, addr: req_addr, data: req_data, ub: req_ub, lb: req_lb});
        m_level++;
        if (req_wr) mem_write(1'b0, req_addr, req_data, req_ub, req_lb);
        else        exp_rsp.push_back(mem_read(1'b0, req_addr));
      end
    end
  end

  // Scoreboard monitor: compares each newly issued operation and each response
  initial begin
    req_t e;
    logic prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stb = 1'b0;
      end else begin
        if (app_wr && app_rd) chk("strobe_exclusive", 64'd1, 64'd0);
        if ((app_wr || app_rd) && !prev_stb) begin
          if (exp_q.size() == 0) begin
            chk("issue_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            m_level--;
            chk("issue_wr", 64'(app_wr), 64'(e.wr));
            chk("issue_addr", 64'(app_addr), 64'(e.addr));
            chk("issue_data", 64'(app_data_out), 64'(e.data));
            chk("issue_be", 64'({app_ub, app_lb}), 64'({e.ub, e.lb}));
            chk("issue_burst", 64'(app_burst_op), 64'd0);
          end
        end
        prev_stb = app_wr || app_rd;
        chk("q_level", 64'(q_level), 64'(m_level));
        chk("req_ready", 64'(req_ready), 64'(m_level != DEPTH));
        if (m_level > DEPTH || m_level < 0) chk("level_range", 64'(m_level), 64'd0);
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else                     chk("rsp_data", 64'(rsp_data), 64'(exp_rsp.pop_front()));
        end
      end
    end
  end

  // Controller model: accepts strobes after random delays, serves from ctl_mem
  initial begin
    logic        c_rd, c_ub, c_lb;
    logic [22:0] c_addr;
    logic [15:0] c_data;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_auto && reset && (app_wr || app_rd)) begin
        c_rd = app_rd; c_addr = app_addr; c_data = app_data_out; c_ub = app_ub; c_lb = app_lb;
        cyc($urandom_range(0, 3));
        app_op_begun = 1'b1;
        cyc(1);
        app_op_begun = 1'b0;
        cyc($urandom_range(0, 2));
        if (c_rd) begin
          app_data_in = mem_read(1'b1, c_addr);
          app_data_ok = 1'b1;
          cyc(1);
          app_data_ok = 1'b0;
        end else begin
          mem_write(1'b1, c_addr, c_data, c_ub, c_lb);
          if ($urandom_range(0, 3) == 0) begin
            app_data_ok = 1'b1;
            cyc(1);
            app_data_ok = 1'b0;
          end
        end
        cyc($urandom_range(0, 3));
        op_finished = 1'b1;
        cyc(1);
        op_finished = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ref_mem[23'h7FFFFF] = 16'h1234;
    ctl_mem[23'h7FFFFF] = 16'h1234;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_level", 64'(q_level), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({app_wr, app_rd, app_ub, app_lb, app_burst_op}), 64'd0);
    chk("rst_app_addr", 64'(app_addr), 64'd0);
    chk("rst_app_data", 64'(app_data_out), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
    reset = 1'b1;
    cyc(2);

    // Single write with a hand-driven handshake
    ctl_auto = 1'b0; ctrlr_good = 1'b1;
    set_req(1'b1, 23'h000123, 16'hBEEF, 1'b1, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    chk("wr_level_after_push", 64'(q_level), 64'd1);
    chk("wr_no_strobe_yet", 64'(app_wr), 64'd0);
    chk("wr_busy", 64'(busy), 64'd1);
    cyc(1);
    chk("wr_strobe", 64'({app_wr, app_rd}), 64'b10);
    chk("wr_addr", 64'(app_addr), 64'h000123);
    chk("wr_data", 64'(app_data_out), 64'hBEEF);
    chk("wr_be", 64'({app_ub, app_lb}), 64'b11);
    cyc(2);
    chk("wr_strobe_held", 64'(app_wr), 64'd1);
    app_op_begun = 1'b1;
    cyc(1);
    app_op_begun = 1'b0;
    chk("wr_strobe_drop", 64'(app_wr), 64'd0);
    chk("wr_busy_wait", 64'(busy), 64'd1);
    app_data_ok = 1'b1;
    cyc(1);
    app_data_ok = 1'b0;
    cyc(3);
    op_finished = 1'b1;
    cyc(1);
    op_finished = 1'b0;
    chk("wr_busy_idle", 64'(busy), 64'd0);
    cyc(2);
    chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
    mem_write(1'b1, 23'h000123, 16'hBEEF, 1'b1, 1'b1);

    // Single read at the top address, response two edges after data_ok
    set_req(1'b0, 23'h7FFFFF, 16'h0000, 1'b1, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    cyc(1);
    chk("rd_strobe", 64'({app_wr, app_rd}), 64'b01);
    chk("rd_addr", 64'(app_addr), 64'h7FFFFF);
    cyc(1);
    app_op_begun = 1'b1;
    cyc(1);
    app_op_begun = 1'b0;
    chk("rd_strobe_drop", 64'(app_rd), 64'd0);
    app_data_in = 16'h1234;
    app_data_ok = 1'b1;
    cyc(1);
    app_data_ok = 1'b0;
    chk("rd_rsp_early", 64'(rsp_valid), 64'd0);
    cyc(1);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'h1234);
    cyc(1);
    chk("rd_rsp_one_cycle", 64'(rsp_valid), 64'd0);
    op_finished = 1'b1;
    cyc(1);
    op_finished = 1'b0;
    drain("rd");

    // Fill with the controller not ready: 9th push is dropped
    ctl_auto = 1'b1; ctrlr_good = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_req(1'b1, 23'(i), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(1);
      if (i == 7) begin
        chk("fill_ready_low", 64'(req_ready), 64'd0);
        chk("fill_level8", 64'(q_level), 64'd8);
      end
    end
    req_valid = 1'b0;
    chk("fill_9th_dropped", 64'(q_level), 64'd8);
    chk("fill_no_issue", 64'({app_wr, app_rd}), 64'd0);
    ctrlr_good = 1'b1;
    drain("fill");

    // Push and pop on the same edge at level 3
    ctrlr_good = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 23'(20 + i), 16'($urandom), 1'b1, 1'b1);
      cyc(1);
    end
    chk("pp_level3", 64'(q_level), 64'd3);
    ctrlr_good = 1'b1;
    set_req(1'b0, 23'd21, 16'h0000, 1'b1, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    chk("pp_level_same", 64'(q_level), 64'd3);
    chk("pp_issued", 64'(app_wr), 64'd1);
    drain("pp");

    // Randomized traffic: continuous pushes/pops wrapping the pointers
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 23'($urandom_range(0, 15));
      req_data  = 16'($urandom);
      req_ub    = 1'($urandom_range(0, 1));
      req_lb    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) ctrlr_good = ~ctrlr_good;
      cyc(1);
    end
    req_valid = 1'b0; ctrlr_good = 1'b1;
    drain("rand");

    // Reset while a read waits for completion
    ctl_auto = 1'b0;
    set_req(1'b0, 23'h000005, 16'h0000, 1'b1, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    cyc(1);
    chk("rr_strobe", 64'(app_rd), 64'd1);
    app_op_begun = 1'b1;
    cyc(1);
    app_op_begun = 1'b0;
    app_data_in = 16'hDEAD;
    app_data_ok = 1'b1;
    #2 reset = 1'b0;
    #1;
    exp_q.delete(); exp_rsp.delete(); m_level = 0;
    chk("rr_strobes_async", 64'({app_wr, app_rd}), 64'd0);
    chk("rr_level", 64'(q_level), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_ready", 64'(req_ready), 64'd1);
    chk("rr_app_regs", 64'({app_addr, app_data_out, app_ub, app_lb}), 64'd0);
    chk("rr_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
    cyc(2);
    app_data_ok = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("rr_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Queue works again after the abort
    ctl_auto = 1'b1;
    set_req(1'b1, 23'd9, 16'hA55A, 1'b1, 1'b0);
    cyc(1);
    set_req(1'b0, 23'd9, 16'h0000, 1'b1, 1'b1);
    cyc(1);
    req_valid = 1'b0;
    drain("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
